// File: rtl/ram_program_loader.sv
// Loads a framed program image from a byte stream into word RAM.
// Holds the CPU in reset until a frame checksum is verified.
module ram_program_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_rst
);

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = ADDR_WIDTH + 1;
  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_PAYLOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [7:0]      cnt_hi;
  logic [15:0]     n_words;
  logic [1:0]      lane;
  logic [IW-1:0]   word_idx;
  logic [IW-1:0]   idx_next;
  logic [7:0]      sum;
  logic [23:0]     word_lo;
  logic [TW-1:0]   tcnt;
  logic [15:0]     count;
  logic            word_end;
  logic            last_word;
  logic            timeout_hit;

  assign count       = {cnt_hi, rx_data};
  assign word_end    = (lane == 2'd3);
  assign idx_next    = word_idx + 1'b1;
  assign last_word   = (17'(idx_next) == 17'(n_words));
  assign timeout_hit = busy && !rx_valid && (tcnt == T_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state decode and state-derived status outputs.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_rst    = 1'b1;
    unique case (state)
      S_IDLE: begin
        if (rx_valid && rx_data == SYNC)
          next_state = S_CNT_HI;
      end
      S_CNT_HI: begin
        busy = 1'b1;
        if (rx_valid)
          next_state = S_CNT_LO;
      end
      S_CNT_LO: begin
        busy = 1'b1;
        if (rx_valid) begin
          if (17'(count) > DEPTH)
            next_state = S_ERROR;
          else if (count == 16'd0)
            next_state = S_CHECK;
          else
            next_state = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        busy = 1'b1;
        if (rx_valid && word_end && last_word)
          next_state = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (rx_valid)
          next_state = (rx_data == sum) ? S_DONE : S_ERROR;
      end
      S_DONE: begin
        done    = 1'b1;
        cpu_rst = 1'b0;
        if (rx_valid && rx_data == SYNC)
          next_state = S_CNT_HI;
      end
      S_ERROR: begin
        error = 1'b1;
        if (rx_valid && rx_data == SYNC)
          next_state = S_CNT_HI;
      end
      default: next_state = S_IDLE;
    endcase
    if (timeout_hit)
      next_state = S_ERROR;
  end

  // Inter-byte idle timer; only runs while a frame is open.
  always_ff @(posedge clk) begin
    if (rst)
      tcnt <= '0;
    else if (rx_valid || !busy)
      tcnt <= '0;
    else
      tcnt <= tcnt + 1'b1;
  end

  // Frame datapath: count capture, word assembly, checksum, RAM write.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_hi         <= '0;
      n_words        <= '0;
      lane           <= '0;
      word_idx       <= '0;
      sum            <= '0;
      word_lo        <= '0;
      ram_we         <= 1'b0;
      ram_write_addr <= '0;
      ram_data       <= '0;
    end else begin
      ram_we <= 1'b0;
      if (rx_valid) begin
        unique case (state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (rx_data == SYNC) begin
              cnt_hi   <= '0;
              n_words  <= '0;
              lane     <= '0;
              word_idx <= '0;
              sum      <= '0;
              word_lo  <= '0;
            end
          end
          S_CNT_HI: cnt_hi <= rx_data;
          S_CNT_LO: n_words <= count;
          S_PAYLOAD: begin
            sum  <= sum + rx_data;
            lane <= lane + 1'b1;
            unique case (lane)
              2'd0: word_lo[7:0]   <= rx_data;
              2'd1: word_lo[15:8]  <= rx_data;
              2'd2: word_lo[23:16] <= rx_data;
              default: begin
                ram_we         <= 1'b1;
                ram_write_addr <= word_idx[ADDR_WIDTH-1:0];
                ram_data       <= DATA_WIDTH'({rx_data, word_lo});
                word_idx       <= idx_next;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_program_loader.sv
// Bench for ram_program_loader: directed frames plus random frames
// checked against a frame-level model of expected writes and status.
module tb_ram_program_loader;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          ram_we;
  logic [AW-1:0] ram_write_addr;
  logic [DW-1:0] ram_data;
  logic          busy;
  logic          done;
  logic          error;
  logic          cpu_rst;

  int total = 0;
  int bad   = 0;

  int          wa[$];
  logic [31:0] wd[$];
  logic [31:0] pay[$];

  always #5 clk = ~clk;

  ram_program_loader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .ram_we(ram_we),
    .ram_write_addr(ram_write_addr),
    .ram_data(ram_data),
    .busy(busy),
    .done(done),
    .error(error),
    .cpu_rst(cpu_rst)
  );

  // Record every cycle with the write strobe high.
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      wa.push_back(int'(ram_write_addr));
      wd.push_back(ram_data);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic flags(input string tag, input bit b, input bit d,
                       input bit e, input bit c);
    check({tag, ".busy"}, 64'(busy), 64'(b));
    check({tag, ".done"}, 64'(done), 64'(d));
    check({tag, ".error"}, 64'(error), 64'(e));
    check({tag, ".cpu_rst"}, 64'(cpu_rst), 64'(c));
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic gap(input int gmax);
    idle($urandom_range(0, gmax));
  endtask

  // Sends pay[] as one frame and checks the writes and final status.
  task automatic play_frame(input string tag, input bit corrupt,
                            input int gmax);
    int          n;
    logic [15:0] nn;
    logic [7:0]  ck;
    logic [7:0]  b;
    logic [31:0] w;
    n  = pay.size();
    nn = 16'(n);
    ck = 8'h00;
    wa.delete();
    wd.delete();
    send(8'hA5);
    gap(gmax);
    send(nn[15:8]);
    gap(gmax);
    send(nn[7:0]);
    gap(gmax);
    for (int i = 0; i < n; i++) begin
      w = pay[i];
      for (int k = 0; k < 4; k++) begin
        b  = w[8*k +: 8];
        ck = ck + b;
        send(b);
        gap(gmax);
      end
    end
    send(corrupt ? ck + 8'h01 : ck);
    flags(tag, 1'b0, !corrupt, corrupt, corrupt);
    check({tag, ".nwr"}, 64'(wa.size()), 64'(n));
    for (int i = 0; i < n && i < wa.size(); i++) begin
      check($sformatf("%s.addr%0d", tag, i), 64'(wa[i]), 64'(i));
      check($sformatf("%s.data%0d", tag, i), 64'(wd[i]), 64'(pay[i]));
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    idle(2);
    flags("rst", 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst.we", 64'(ram_we), 64'(0));
    check("rst.addr", 64'(ram_write_addr), 64'(0));
    check("rst.data", 64'(ram_data), 64'(0));
    rst = 1'b0;
    idle(1);

    send(8'h11);
    send(8'h22);
    flags("noise", 1'b0, 1'b0, 1'b0, 1'b1);

    pay.delete();
    pay.push_back(32'h12345678);
    pay.push_back(32'hDEADBEEF);
    play_frame("good", 1'b0, 0);
    play_frame("badck", 1'b1, 0);

    for (int r = 0; r < 5; r++) begin
      pay.delete();
      for (int i = 0; i < int'($urandom_range(1, 8)); i++)
        pay.push_back($urandom);
      play_frame($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), 3);
    end

    wa.delete();
    send(8'hA5);
    send(8'h00);
    send(8'h41);
    flags("over", 1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);
    check("over.nwr", 64'(wa.size()), 64'(0));

    pay.delete();
    for (int i = 0; i < (1 << AW); i++)
      pay.push_back($urandom);
    play_frame("max", 1'b0, 0);
    if (wa.size() > 0)
      check("max.last", 64'(wa[wa.size()-1]), 64'((1 << AW) - 1));

    wa.delete();
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    send(8'h12);
    idle(TO - 1);
    flags("tmo.pre", 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    flags("tmo", 1'b0, 1'b0, 1'b1, 1'b1);
    check("tmo.nwr", 64'(wa.size()), 64'(0));

    wa.delete();
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    rx_valid = 1'b1;
    rx_data  = 8'h04;
    rst      = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rst      = 1'b0;
    idle(2);
    flags("mrst", 1'b0, 1'b0, 1'b0, 1'b1);
    check("mrst.nwr", 64'(wa.size()), 64'(0));
    check("mrst.data", 64'(ram_data), 64'(0));
    send(8'h00);
    send(8'h01);
    flags("mrst.nosync", 1'b0, 1'b0, 1'b0, 1'b1);

    pay.delete();
    pay.push_back($urandom);
    play_frame("pre", 1'b0, 1);
    wa.delete();
    send(8'hA5);
    flags("rest.a5", 1'b1, 1'b0, 1'b0, 1'b1);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    flags("zero", 1'b0, 1'b1, 1'b0, 1'b0);
    check("zero.nwr", 64'(wa.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_program_loader.md
RAM_PROGRAM_LOADER -- requirements
Module: ram_program_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, RAM word width; fixed at 32 in this revision.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, RAM address width, holding 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter TIMEOUT, default 1000000, idle-cycle limit between bytes inside a frame.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high (ports clk, rst).
REQ-005 SHALL have port clk, input, 1, sole clock, all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port rx_valid, input, 1, one-cycle strobe: rx_data valid this cycle.
REQ-008 SHALL have port rx_data, input, 8, received byte.
REQ-009 SHALL have port ram_we, output, 1, RAM write enable.
REQ-010 SHALL have port ram_write_addr, output, ADDR_WIDTH, RAM word write address.
REQ-011 SHALL have port ram_data, output, DATA_WIDTH, RAM write data.
REQ-012 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-013 SHALL have port done, output, 1, high after a verified load, level.
REQ-014 SHALL have port error, output, 1, high after a failed load, level.
REQ-015 SHALL have port cpu_rst, output, 1, holds the CPU in reset until a verified load.

Function
REQ-016 Frame: sync 0xA5, count high byte, count low byte, N words of 4 bytes each little-endian (first byte to bits 7:0), then 1 checksum byte.
REQ-017 Checksum: 8-bit modulo-256 sum of payload bytes only; sync and count bytes are excluded.
REQ-018 States: IDLE, CNT_HI, CNT_LO, PAYLOAD, CHECK, DONE, ERROR.
REQ-019 IDLE: 0xA5 moves the FSM to CNT_HI; any other byte is ignored.
REQ-020 CNT_HI: a byte moves the FSM to CNT_LO. CNT_LO: a byte completes N.
REQ-021 After CNT_LO: N > 2**ADDR_WIDTH goes to ERROR; N == 0 goes to CHECK; otherwise the FSM goes to PAYLOAD.
REQ-022 PAYLOAD: byte lane counter 0..3 and a word index (ADDR_WIDTH+1 bits) advance per byte; the FSM goes to CHECK after byte 4*N.
REQ-023 Write: ram_we high for exactly one cycle, the cycle after the 4th byte of a word is accepted.
REQ-024 During the write pulse, ram_write_addr SHALL equal the word index (0 first) and ram_data the assembled word; the address never wraps.
REQ-025 CHECK: a checksum byte equal to the running sum goes to DONE; a mismatch goes to ERROR.
REQ-026 Payload writes are not undone on error.
REQ-027 busy is high in CNT_HI, CNT_LO, PAYLOAD and CHECK.
REQ-028 done is high only in DONE; error is high only in ERROR.
REQ-029 cpu_rst is low only in DONE.
REQ-030 DONE/ERROR: a byte 0xA5 restarts at CNT_HI, clears done/error and reasserts cpu_rst next cycle; other bytes are ignored.
REQ-031 Timeout: the counter clears on every accepted byte and counts while busy; reaching TIMEOUT with no byte goes to ERROR.
REQ-032 Back-to-back rx_valid on consecutive cycles SHALL be accepted without loss; there is no backpressure.
REQ-033 ram_we SHALL be low in every state except during the REQ-023 pulse.

Reset
REQ-034 On rst: state IDLE, ram_we=0, ram_write_addr=0, ram_data=0, busy=0, done=0, error=0, cpu_rst=1, all counters and the checksum cleared.
REQ-035 rst mid-frame SHALL abort the frame; any write pending for that cycle is suppressed; the next frame requires a new 0xA5.

Verification
REQ-036 Normal load: A5 00 02 78 56 34 12 EF BE AD DE 4C -> writes addr0=0x12345678 and addr1=0xDEADBEEF; done=1, cpu_rst=0, error=0.
REQ-037 Bad checksum: same frame ending 4D -> both writes occur; error=1, done=0, cpu_rst=1.
REQ-038 Oversize: A5 00 41 (ADDR_WIDTH=6) -> error=1 after the count, no ram_we; A5 00 40 with 256 bytes -> last write addr 63, no wrap.
REQ-039 Timeout and noise: bytes 11 22 in IDLE ignored; A5 00 01 12 then silence for TIMEOUT cycles -> error=1, no write.
REQ-040 Reset/restart: rst asserted after byte 3 of word 0 -> no write, IDLE; after DONE, A5 00 00 00 -> cpu_rst pulses high, then done=1.
